// File: rtl/core_pkg.sv
// Shared core types and widths used by the fetch front end.
package core_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_W     = 32;
  localparam int FETCH_WIDTH = 2;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch queue: two entries pushed per write, up to two popped per cycle,
// head and head+1 presented combinationally.
module fetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push_en,
  input  fq_entry_t push_data [FETCH_WIDTH],
  input  logic [1:0] pop_cnt,
  input  logic      clear,
  output logic [CW-1:0] count,
  output fq_entry_t head [FETCH_WIDTH]
);

  fq_entry_t     mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // observed when count says it is valid, so resetting it would add fanout for nothing.
  always_ff @(posedge clk) begin
    if (push_en && !clear) begin
      mem[wr_ptr]          <= push_data[0];
      mem[wr_ptr + PW'(1)] <= push_data[1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PW'(2);
      rd_ptr <= rd_ptr + PW'(pop_cnt);
      count  <= count + (push_en ? CW'(2) : CW'(0)) - CW'(pop_cnt);
    end
  end

  assign head[0] = mem[rd_ptr];
  assign head[1] = mem[rd_ptr + PW'(1)];

endmodule

// File: rtl/fetch_unit.sv
// Dual-lane fetch front end: PC, paired imem requests under queue credit,
// flush/redirect handling with in-flight response drop, two-lane decode output.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0,
  parameter int              FQ_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_ren,
  output logic [XLEN-1:0]        imem_addr0,
  output logic [XLEN-1:0]        imem_addr1,
  input  logic                   imem_valid,
  input  logic [INSTR_W-1:0]     imem_rdata0,
  input  logic [INSTR_W-1:0]     imem_rdata1,
  input  logic                   flush_pipeline,
  input  logic [XLEN-1:0]        flush_pc,
  input  logic                   redirect_en,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   decode_ready,
  output logic [FETCH_WIDTH-1:0] if_valid,
  output logic [INSTR_W-1:0]     if_instr [FETCH_WIDTH],
  output logic [XLEN-1:0]        if_pc    [FETCH_WIDTH],
  output logic                   fetch_stall
);

  localparam int              CW         = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW:0]     CREDIT_MAX = (CW+1)'(FQ_DEPTH - 2);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            outstanding;
  logic            drop;

  logic            redir;
  logic [XLEN-1:0] target;
  logic [CW:0]     credit;
  logic            credit_ok;
  logic            can_issue;
  logic            push_en;
  logic [1:0]      pop_cnt;
  logic [CW-1:0]   fq_count;
  fq_entry_t       push_data [FETCH_WIDTH];
  fq_entry_t       head      [FETCH_WIDTH];

  // NOTE: every signal in this block is assigned on every path, so no latch can be inferred.
  always_comb begin
    redir     = flush_pipeline || redirect_en;
    target    = flush_pipeline ? flush_pc : redirect_pc;
    // A response returning this cycle still holds its two slots of credit.
    credit    = {1'b0, fq_count} + (outstanding ? (CW+1)'(2) : (CW+1)'(0));
    credit_ok = (credit <= CREDIT_MAX);
    can_issue = !outstanding || imem_valid;
    imem_ren    = reset && !redir && credit_ok && can_issue;
    fetch_stall = reset && !redir && !credit_ok;
    push_en   = imem_valid && outstanding && !drop && !redir;
    if_valid  = redir ? '0 : {fq_count >= CW'(2), fq_count != '0};
    pop_cnt   = decode_ready ? ({1'b0, if_valid[0]} + {1'b0, if_valid[1]}) : 2'd0;
    push_data[0] = '{instr: imem_rdata0, pc: req_pc};
    push_data[1] = '{instr: imem_rdata1, pc: req_pc + XLEN'(4)};
  end

  // NOTE: non-blocking updates let a later assignment in the same edge override an
  // earlier one, so a new request sets outstanding even as the previous response clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else if (redir) begin
      pc          <= target & ~XLEN'(3);
      outstanding <= outstanding && !imem_valid;
      drop        <= outstanding && !imem_valid;
    end else begin
      if (imem_valid && outstanding) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end
      if (imem_ren) begin
        outstanding <= 1'b1;
        req_pc      <= pc;
        pc          <= pc + XLEN'(8);
      end
    end
  end

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fetch_queue (
    .clk       (clk),
    .reset     (reset),
    .push_en   (push_en),
    .push_data (push_data),
    .pop_cnt   (pop_cnt),
    .clear     (redir),
    .count     (fq_count),
    .head      (head)
  );

  assign imem_addr0  = pc;
  assign imem_addr1  = pc + XLEN'(4);
  assign if_instr[0] = head[0].instr;
  assign if_instr[1] = head[1].instr;
  assign if_pc[0]    = head[0].pc;
  assign if_pc[1]    = head[1].pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency ROM model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_ren;
  logic [31:0] imem_addr0, imem_addr1;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata0 = '0, imem_rdata1 = '0;
  logic        flush_pipeline = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        decode_ready = 1'b1;
  logic [1:0]  if_valid;
  logic [31:0] if_instr [2];
  logic [31:0] if_pc [2];
  logic        fetch_stall;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_pc;

  fetch_unit #(.RESET_PC(32'h0), .FQ_DEPTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_ren       (imem_ren),
    .imem_addr0     (imem_addr0),
    .imem_addr1     (imem_addr1),
    .imem_valid     (imem_valid),
    .imem_rdata0    (imem_rdata0),
    .imem_rdata1    (imem_rdata1),
    .flush_pipeline (flush_pipeline),
    .flush_pc       (flush_pc),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .decode_ready   (decode_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fetch_stall    (fetch_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  always @(posedge clk) begin
    imem_valid  <= imem_ren;
    imem_rdata0 <= rom(imem_addr0);
    imem_rdata1 <= rom(imem_addr1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  // Expects a full pair every cycle, in program order from exp_pc.
  task automatic stream_check(input int n);
    for (int i = 0; i < n; i++) begin
      check("stream_valid", 32'(if_valid), 32'h3);
      check("stream_pc0", if_pc[0], exp_pc);
      check("stream_pc1", if_pc[1], exp_pc + 32'd4);
      check("stream_instr0", if_instr[0], rom(exp_pc));
      check("stream_instr1", if_instr[1], rom(exp_pc + 32'd4));
      exp_pc = exp_pc + 32'd8;
      tick();
      #1;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    #1;
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_ren", 32'(imem_ren), 32'h0);
    check("rst_stall", 32'(fetch_stall), 32'h0);
    check("rst_addr0", imem_addr0, 32'h0);

    // Start-up and streaming
    reset = 1'b1;
    #1;
    check("c_ren", 32'(imem_ren), 32'h1);
    check("c_addr0", imem_addr0, 32'h0);
    check("c_addr1", imem_addr1, 32'h4);
    tick(); #1;
    check("c1_if_valid", 32'(if_valid), 32'h0);
    check("c1_addr0", imem_addr0, 32'h8);
    check("c1_ren", 32'(imem_ren), 32'h1);
    tick(); #1;
    exp_pc = 32'h0;
    stream_check(3);

    // Backpressure from reset
    decode_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) check("bp_ren_c3", 32'(imem_ren), 32'h1);
      if (i == 5) check("bp_stall_c5", 32'(fetch_stall), 32'h1);
      if (i == 9) begin
        check("bp_stall", 32'(fetch_stall), 32'h1);
        check("bp_ren", 32'(imem_ren), 32'h0);
        check("bp_valid", 32'(if_valid), 32'h3);
        check("bp_pc0", if_pc[0], 32'h0);
      end
      tick(); #1;
    end
    decode_ready = 1'b1;
    #1;
    exp_pc = 32'h0;
    stream_check(12);

    // Redirect while the 0x08 request is in flight
    do_reset();
    check("rd_addr0_c", imem_addr0, 32'h0);
    tick(); #1;
    check("rd_addr0_c1", imem_addr0, 32'h8);
    check("rd_ren_c1", 32'(imem_ren), 32'h1);
    tick();
    redirect_en = 1'b1;
    redirect_pc = 32'h40;
    #1;
    check("rd_valid_r", 32'(if_valid), 32'h0);
    check("rd_ren_r", 32'(imem_ren), 32'h0);
    tick();
    redirect_en = 1'b0;
    #1;
    check("rd_addr0_r1", imem_addr0, 32'h40);
    check("rd_valid_r1", 32'(if_valid), 32'h0);
    tick(); #1;
    check("rd_valid_r2", 32'(if_valid), 32'h0);
    tick(); #1;
    check("rd_valid_r3", 32'(if_valid), 32'h3);
    check("rd_pc0_r3", if_pc[0], 32'h40);
    check("rd_pc1_r3", if_pc[1], 32'h44);
    check("rd_instr0_r3", if_instr[0], rom(32'h40));

    // Flush beats redirect, queue full beforehand
    decode_ready = 1'b0;
    repeat (8) tick();
    #1;
    check("fl_pre_stall", 32'(fetch_stall), 32'h1);
    flush_pipeline = 1'b1;
    flush_pc       = 32'h100;
    redirect_en    = 1'b1;
    redirect_pc    = 32'h80;
    #1;
    check("fl_valid_r", 32'(if_valid), 32'h0);
    check("fl_stall_r", 32'(fetch_stall), 32'h0);
    check("fl_ren_r", 32'(imem_ren), 32'h0);
    tick();
    flush_pipeline = 1'b0;
    redirect_en    = 1'b0;
    #1;
    check("fl_addr0_r1", imem_addr0, 32'h100);
    check("fl_valid_r1", 32'(if_valid), 32'h0);
    tick(); #1;
    check("fl_valid_r2", 32'(if_valid), 32'h0);
    tick(); #1;
    check("fl_valid_r3", 32'(if_valid), 32'h3);
    check("fl_pc0_r3", if_pc[0], 32'h100);
    check("fl_pc1_r3", if_pc[1], 32'h104);

    // Misaligned redirect target
    decode_ready = 1'b1;
    redirect_en  = 1'b1;
    redirect_pc  = 32'h23;
    #1;
    tick();
    redirect_en = 1'b0;
    #1;
    check("mis_addr0", imem_addr0, 32'h20);
    check("mis_addr1", imem_addr1, 32'h24);
    tick(); #1;
    tick(); #1;
    check("mis_pc0", if_pc[0], 32'h20);
    check("mis_valid", 32'(if_valid), 32'h3);

    // Async reset with six entries queued and a response on the bus
    decode_ready = 1'b0;
    redirect_en  = 1'b1;
    redirect_pc  = 32'h200;
    #1;
    tick();
    redirect_en = 1'b0;
    #1;
    repeat (4) begin
      tick(); #1;
    end
    check("ar_pre_valid", 32'(if_valid), 32'h3);
    check("ar_pre_pc0", if_pc[0], 32'h200);
    check("ar_pre_stall", 32'(fetch_stall), 32'h1);
    check("ar_pre_imem_valid", 32'(imem_valid), 32'h1);
    reset = 1'b0;
    #1;
    check("ar_valid", 32'(if_valid), 32'h0);
    check("ar_ren", 32'(imem_ren), 32'h0);
    check("ar_stall", 32'(fetch_stall), 32'h0);
    check("ar_addr0", imem_addr0, 32'h0);
    reset = 1'b1;
    #1;
    check("ar_rel_ren", 32'(imem_ren), 32'h1);
    decode_ready = 1'b1;
    tick(); #1;
    check("ar_c1_valid", 32'(if_valid), 32'h0);
    check("ar_c1_addr0", imem_addr0, 32'h8);
    tick(); #1;
    check("ar_c2_valid", 32'(if_valid), 32'h3);
    check("ar_c2_pc0", if_pc[0], 32'h0);
    check("ar_c2_pc1", if_pc[1], 32'h4);
    check("ar_c2_instr1", if_instr[1], rom(32'h4));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
